mbr_sector_parser: RTL and testbench

MBR_SECTOR_PARSER -- requirements
Module: MBRSectorParser

---
 rtl/mbr_sector_parser.sv | 143 ++++++++++++++
 tb/tb_mbr_sector_parser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mbr_sector_parser.sv
// Streams one 512-byte MBR sector, captures the four partition starting LBAs
// into shadow registers and commits them atomically when the 0x55AA signature checks out.
module mbr_sector_parser (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_Start,
  input  logic [7:0]  io_Data,
  input  logic        io_DataValid,
  output logic        io_DataReady,
  output logic [31:0] io_Partition1Start,
  output logic [31:0] io_Partition2Start,
  output logic [31:0] io_Partition3Start,
  output logic [31:0] io_Partition4Start,
  output logic        io_Busy,
  output logic        io_Done,
  output logic        io_Error
);

  localparam logic [8:0] TABLE_BASE    = 9'h1C6;
  localparam logic [8:0] SIG_LO_OFFSET = 9'd510;
  localparam logic [8:0] SIG_HI_OFFSET = 9'd511;
  localparam logic [7:0] SIG_LO_BYTE   = 8'h55;
  localparam logic [7:0] SIG_HI_BYTE   = 8'hAA;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t     state_reg;
  logic [8:0] byte_cnt_reg;
  logic       sig_lo_reg;
  logic       sig_hi_reg;
  logic       ready_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       error_reg;

  logic       accept;
  logic       start_parse;
  logic       commit;

  // ready_reg is only ever high in RECV, so it alone qualifies a byte transfer
  assign accept      = ready_reg & io_DataValid;
  assign start_parse = (state_reg == IDLE) & io_Start;
  assign commit      = (state_reg == CHECK) & sig_lo_reg & sig_hi_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= '0;
      sig_lo_reg   <= 1'b0;
      sig_hi_reg   <= 1'b0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (io_Start) begin
            state_reg    <= RECV;
            byte_cnt_reg <= '0;
            sig_lo_reg   <= 1'b0;
            sig_hi_reg   <= 1'b0;
            error_reg    <= 1'b0;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b1;
          end
        end
        RECV: begin
          if (accept) begin
            // The counter simply wraps after offset 511; the offset compare drives the exit
            byte_cnt_reg <= byte_cnt_reg + 9'd1;
            if (byte_cnt_reg == SIG_LO_OFFSET) begin
              sig_lo_reg <= (io_Data == SIG_LO_BYTE);
            end
            if (byte_cnt_reg == SIG_HI_OFFSET) begin
              sig_hi_reg <= (io_Data == SIG_HI_BYTE);
              state_reg  <= CHECK;
              ready_reg  <= 1'b0;
              done_reg   <= 1'b1;
            end
          end
        end
        CHECK: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          error_reg <= ~(sig_lo_reg & sig_hi_reg);
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // One shadow/committed pair per partition entry; all four share the commit strobe
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_entry
      localparam logic [8:0] ENTRY_BASE = TABLE_BASE + 9'(16 * gi);

      logic [31:0] shadow_reg;
      logic [31:0] committed_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          shadow_reg    <= '0;
          committed_reg <= '0;
        end else begin
          if (start_parse) begin
            shadow_reg <= '0;
          end else if (accept) begin
            for (int k = 0; k < 4; k++) begin
              if (byte_cnt_reg == ENTRY_BASE + 9'(k)) begin
                shadow_reg[8*k +: 8] <= io_Data;
              end
            end
          end
          if (commit) begin
            committed_reg <= shadow_reg;
          end
        end
      end
    end
  endgenerate

  assign io_Partition1Start = gen_entry[0].committed_reg;
  assign io_Partition2Start = gen_entry[1].committed_reg;
  assign io_Partition3Start = gen_entry[2].committed_reg;
  assign io_Partition4Start = gen_entry[3].committed_reg;

  assign io_DataReady = ready_reg;
  assign io_Busy      = busy_reg;
  assign io_Done      = done_reg;
  assign io_Error     = error_reg;

endmodule

// File: tb/tb_mbr_sector_parser.sv
// Bench for mbr_sector_parser: table of sectors with expected committed LBAs,
// a scoreboard queue of expected results, plus reset-abort and held-start sequences.
module tb_mbr_sector_parser;

  logic        clock;
  logic        reset;
  logic        io_Start;
  logic [7:0]  io_Data;
  logic        io_DataValid;
  logic        io_DataReady;
  logic [31:0] io_Partition1Start;
  logic [31:0] io_Partition2Start;
  logic [31:0] io_Partition3Start;
  logic [31:0] io_Partition4Start;
  logic        io_Busy;
  logic        io_Done;
  logic        io_Error;

  mbr_sector_parser dut (
    .clock              (clock),
    .reset              (reset),
    .io_Start           (io_Start),
    .io_Data            (io_Data),
    .io_DataValid       (io_DataValid),
    .io_DataReady       (io_DataReady),
    .io_Partition1Start (io_Partition1Start),
    .io_Partition2Start (io_Partition2Start),
    .io_Partition3Start (io_Partition3Start),
    .io_Partition4Start (io_Partition4Start),
    .io_Busy            (io_Busy),
    .io_Done            (io_Done),
    .io_Error           (io_Error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0][31:0] lba;
    logic [7:0]       sig_lo;
    logic [7:0]       sig_hi;
    int               gap;       // 0: no gaps, 1: valid toggles 1/0, 2: random gaps
    int               start_at;  // pulse io_Start while this byte index is offered, -1 none
    logic [3:0][31:0] exp_lba;
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic [3:0][31:0] lba;
    logic             err;
  } exp_t;

  vec_t             vecs [7];
  exp_t             sb_q [$];
  logic [7:0]       sector_mem [512];
  logic [3:0][31:0] model_prev;
  int               n_checks;
  int               n_fail;

  function automatic logic [3:0][31:0] mk(input logic [31:0] l1, l2, l3, l4);
    logic [3:0][31:0] r;
    r[0] = l1; r[1] = l2; r[2] = l3; r[3] = l4;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] part_out(input int n);
    case (n)
      0: return io_Partition1Start;
      1: return io_Partition2Start;
      2: return io_Partition3Start;
      default: return io_Partition4Start;
    endcase
  endfunction

  task automatic build_sector(input logic [3:0][31:0] lba, input logic [7:0] lo, input logic [7:0] hi);
    for (int i = 0; i < 512; i++) sector_mem[i] = 8'((i * 37 + 11) & 255);
    for (int n = 0; n < 4; n++)
      for (int k = 0; k < 4; k++)
        sector_mem[454 + 16 * n + k] = lba[n][8*k +: 8];
    sector_mem[510] = lo;
    sector_mem[511] = hi;
  endtask

  task automatic run_parse(input int vi, input bit hold, input bit skip_start);
    vec_t v;
    exp_t e;
    int   idx, cyc, first, last, done_cycle;
    bit   valid, acc;
    v = vecs[vi];
    build_sector(v.lba, v.sig_lo, v.sig_hi);
    e.lba = v.exp_lba;
    e.err = v.exp_err;
    sb_q.push_back(e);
    if (!skip_start) begin
      io_Start = 1'b1;
      @(negedge clock);
    end
    io_Start = hold;
    check("busy_in_recv", {31'b0, io_Busy}, 32'd1);
    check("ready_in_recv", {31'b0, io_DataReady}, 32'd1);
    idx = 0; cyc = 0; first = -1; last = -1; done_cycle = -1;
    while (cyc < 4000) begin
      if (io_Done) begin
        done_cycle = cyc;
        break;
      end
      if (v.start_at >= 0) io_Start = (idx == v.start_at) || hold;
      case (v.gap)
        0: valid = 1'b1;
        1: valid = (cyc % 2 == 0);
        default: valid = ($urandom_range(0, 3) != 0);
      endcase
      valid = valid && (idx < 512);
      io_DataValid = valid;
      io_Data = sector_mem[(idx < 512) ? idx : 0];
      acc = valid && io_DataReady;
      @(negedge clock);
      if (acc) begin
        if (first < 0) first = cyc;
        last = cyc;
        idx++;
      end
      cyc++;
    end
    io_DataValid = 1'b0;
    io_Start = hold;
    check("done_seen", {31'b0, done_cycle >= 0}, 32'd1);
    check("bytes_consumed", idx, 512);
    check("done_latency", done_cycle, last + 1);
    // Cycles from first accepted byte through the io_Done cycle, both inclusive
    if (v.gap == 0) check("done_span", done_cycle - first + 1, 513);
    check("ready_in_check", {31'b0, io_DataReady}, 32'd0);
    check("error_in_check", {31'b0, io_Error}, 32'd0);
    for (int n = 0; n < 4; n++) check($sformatf("hold_p%0d_in_check", n + 1), part_out(n), model_prev[n]);
    @(negedge clock);
    e = sb_q.pop_front();
    check("done_one_cycle", {31'b0, io_Done}, 32'd0);
    check("busy_after", {31'b0, io_Busy}, 32'd0);
    for (int n = 0; n < 4; n++) check($sformatf("p%0d_after", n + 1), part_out(n), e.lba[n]);
    check("error_after", {31'b0, io_Error}, {31'b0, e.err});
    model_prev = e.lba;
    $display("parse vec %0d: p1=%08h p2=%08h p3=%08h p4=%08h err=%0d done_cycle=%0d",
             vi, io_Partition1Start, io_Partition2Start, io_Partition3Start,
             io_Partition4Start, io_Error, done_cycle);
  endtask

  task automatic abort_after_300();
    int idx, cyc;
    bit acc;
    build_sector(mk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444), 8'h55, 8'hAA);
    io_Start = 1'b1;
    @(negedge clock);
    io_Start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 300 && cyc < 1000) begin
      io_DataValid = 1'b1;
      io_Data = sector_mem[idx];
      acc = io_DataReady;
      @(negedge clock);
      if (acc) idx++;
      cyc++;
    end
    check("abort_reached_300", idx, 300);
    check("abort_pre_p1_nonzero", io_Partition1Start, model_prev[0]);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, io_Busy}, 32'd0);
    check("abort_ready", {31'b0, io_DataReady}, 32'd0);
    check("abort_done", {31'b0, io_Done}, 32'd0);
    check("abort_error", {31'b0, io_Error}, 32'd0);
    for (int n = 0; n < 4; n++) check($sformatf("abort_p%0d", n + 1), part_out(n), 32'd0);
    io_DataValid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_prev = '0;
    @(negedge clock);
    check("abort_no_done", {31'b0, io_Done}, 32'd0);
    $display("abort after %0d bytes: busy=%0d p1=%08h", idx, io_Busy, io_Partition1Start);
  endtask

  initial begin
    logic [3:0][31:0] a_lba, b_lba, c_lba, ff_lba;
    n_checks = 0;
    n_fail = 0;
    model_prev = '0;
    a_lba  = mk(32'h00000800, 32'h00100000, 32'h12345678, 32'h00000000);
    b_lba  = mk(32'hDEADBEEF, 32'hCAFEBABE, 32'h0000003F, 32'hFFFFFFFF);
    c_lba  = mk(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004);
    ff_lba = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    vecs[0] = '{lba: a_lba,  sig_lo: 8'h55, sig_hi: 8'hAA, gap: 0, start_at: -1, exp_lba: a_lba, exp_err: 1'b0};
    vecs[1] = '{lba: a_lba,  sig_lo: 8'h55, sig_hi: 8'hAA, gap: 1, start_at: -1, exp_lba: a_lba, exp_err: 1'b0};
    vecs[2] = '{lba: ff_lba, sig_lo: 8'h55, sig_hi: 8'hAB, gap: 0, start_at: -1, exp_lba: a_lba, exp_err: 1'b1};
    vecs[3] = '{lba: a_lba,  sig_lo: 8'h55, sig_hi: 8'hAA, gap: 0, start_at: -1, exp_lba: a_lba, exp_err: 1'b0};
    vecs[4] = '{lba: b_lba,  sig_lo: 8'h55, sig_hi: 8'hAA, gap: 2, start_at: 100, exp_lba: b_lba, exp_err: 1'b0};
    vecs[5] = '{lba: c_lba,  sig_lo: 8'h54, sig_hi: 8'hAA, gap: 0, start_at: -1, exp_lba: b_lba, exp_err: 1'b1};
    vecs[6] = '{lba: c_lba,  sig_lo: 8'h55, sig_hi: 8'hAA, gap: 1, start_at: -1, exp_lba: c_lba, exp_err: 1'b0};

    reset = 1'b0;
    io_Start = 1'b0;
    io_Data = 8'h00;
    io_DataValid = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_busy", {31'b0, io_Busy}, 32'd0);
    check("reset_done", {31'b0, io_Done}, 32'd0);
    check("reset_error", {31'b0, io_Error}, 32'd0);
    check("reset_ready", {31'b0, io_DataReady}, 32'd0);
    for (int n = 0; n < 4; n++) check($sformatf("reset_p%0d", n + 1), part_out(n), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Data offered while idle must never be taken
    io_DataValid = 1'b1;
    io_Data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check($sformatf("idle_ready_%0d", i), {31'b0, io_DataReady}, 32'd0);
      check($sformatf("idle_busy_%0d", i), {31'b0, io_Busy}, 32'd0);
    end

    for (int vi = 0; vi < 7; vi++) run_parse(vi, 1'b0, 1'b0);

    abort_after_300();
    run_parse(4, 1'b0, 1'b0);

    // io_Start held through the whole parse restarts right after the IDLE cycle
    run_parse(0, 1'b1, 1'b0);
    @(negedge clock);
    check("restart_busy", {31'b0, io_Busy}, 32'd1);
    check("restart_ready", {31'b0, io_DataReady}, 32'd1);
    run_parse(6, 1'b0, 1'b1);

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
